md_sequencer: RTL and testbench
===============================

Name: md_sequencer

Overview:
- Multi-cycle multiply/divide sequencer for the 5-stage pipeline; owns the HI/LO registers and the MD unit.
- Accepts mult/div/mthi/mtlo from the EX stage, holds the unit busy for a fixed latency and commits HI/LO at the end.
- Generates the stall request that freezes IF/ID and bubbles ID/EX while a D-stage MD instruction must wait.

Parameters:
MUL_CYCLES, 5, busy cycles for MULT/MULTU (legal 1..15)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal 1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start_i  input  1  EX-stage instruction is an MD op; qualifies md_op_i
md_op_i  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved (no-op)
a_i  input  32  forwarded rs value from EX
b_i  input  32  forwarded rt value from EX
d_uses_md_i  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
hi_o  output  32  committed HI
lo_o  output  32  committed LO
busy_o  output  1  multi-cycle op in flight
stall_o  output  1  stall request to hazard logic

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, counter 0, hi_o=0, lo_o=0, busy_o=0, pending HI/LO=0. stall_o is 0 because it is derived from start_i, busy_o and d_uses_md_i.
- States: IDLE, MUL, DIV.
- IDLE, start_i=1 with op MULT/MULTU:
  - Latch the 64-bit product into pending {HI,LO}. Signed for MULT, unsigned for MULTU.
  - Load the counter with MUL_CYCLES. Go to MUL.
  - busy_o=1 from the next cycle.
- IDLE, start_i=1 with op DIV/DIVU:
  - Latch pending LO=quotient and HI=remainder. Signed ops truncate toward zero and the remainder takes the sign of the dividend.
  - Load the counter with DIV_CYCLES. Go to DIV.
- Divide by zero (b_i=0): pending LO=32'hFFFF_FFFF, HI=a_i. Latency is unchanged.
- Signed overflow (a_i=32'h8000_0000, b_i=32'hFFFF_FFFF, DIV): LO=32'h8000_0000, HI=0.
- MTHI/MTLO in IDLE: write a_i to hi_o/lo_o at the next edge. Single cycle, no busy. The other register is unchanged.
- MUL/DIV: the counter decrements each cycle. When it reaches 1:
  - Commit pending to hi_o/lo_o at that edge and return to IDLE.
  - busy_o falls in the same edge, so the total busy_o high time is exactly N cycles.
- start_i while busy_o=1: ignored. Hazard logic guarantees this never happens; the bench flags it as an error.
- Reserved md_op_i with start_i: no effect.
- stall_o = d_uses_md_i & (busy_o | start_i). This is combinational.
  - Includes the cycle in which start_i is asserted, so mfhi/mflo in D never reads stale HI/LO.
  - Deasserts in the cycle after commit.
- Reset mid-operation aborts the operation: HI/LO return to 0 and nothing is committed.
- Outputs hi_o/lo_o change only on a commit, an MTHI/MTLO write, or reset.

Optional Feature:
MD_CANCEL_EN
- Defined: adds input cancel_i (1 bit), driven when the instruction in EX is flushed.
  - cancel_i with start_i in IDLE suppresses the start.
  - cancel_i in MUL/DIV returns to IDLE next edge without committing; HI/LO keep their prior values and busy_o falls.
  - cancel_i has priority over the commit in the final cycle.
- Undefined: the port is absent and every accepted operation always completes.

Test Plan:
1. Reset low mid-DIV (cycle 4) -> busy_o=0, hi_o=lo_o=0 immediately; no later commit.
2. MULT a=32'hFFFF_FFFE (-2), b=3 -> busy_o high 5 cycles; then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA. MULTU with the same operands -> HI=2, LO=32'hFFFF_FFFA.
3. DIV a=-7, b=2 -> after 10 cycles LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF. DIVU a=7, b=0 -> LO=32'hFFFF_FFFF, HI=7.
4. MULT started with d_uses_md_i=1 held -> stall_o=1 in the start cycle and 5 busy cycles (6 total), 0 the cycle after commit. Same run with d_uses_md_i=0 -> stall_o=0 throughout.
5. MTHI a=32'h1234_5678 then MTLO a=32'h9 on consecutive cycles -> hi_o=32'h1234_5678, lo_o=9, busy_o never asserted. Start during MUL busy -> ignored, result equals the first op.
6. (MD_CANCEL_EN) DIV started, cancel_i at cycle 3 -> busy_o low at cycle 4; HI/LO keep their pre-DIV values.

Source files
------------

// File: rtl/md_sequencer_if.sv
// Bundle between the EX stage and hazard logic on one side and the multiply/divide sequencer on the other.
// The cancel_i signal is present only when MD_CANCEL_EN is defined.
interface md_sequencer_if;
  logic        start_i;
  logic [2:0]  md_op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        d_uses_md_i;
`ifdef MD_CANCEL_EN
  logic        cancel_i;
`endif
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy_o;
  logic        stall_o;

  modport master (
    output start_i, md_op_i, a_i, b_i, d_uses_md_i,
`ifdef MD_CANCEL_EN
    output cancel_i,
`endif
    input  hi_o, lo_o, busy_o, stall_o
  );

  modport slave (
    input  start_i, md_op_i, a_i, b_i, d_uses_md_i,
`ifdef MD_CANCEL_EN
    input  cancel_i,
`endif
    output hi_o, lo_o, busy_o, stall_o
  );
endinterface

// File: rtl/md_sequencer.sv
// Multi-cycle MULT/DIV sequencer that owns HI/LO. The result is computed at issue, held pending, and committed after a fixed latency.
// Optional MD_CANCEL_EN adds cancel_i, which squashes a start or an in-flight operation.
module md_sequencer #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic           clk,
  input logic           reset,
  md_sequencer_if.slave md
);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

  state_t             state;
  state_t             next_state;
  logic [3:0]         cnt;
  logic [31:0]        hi_q;
  logic [31:0]        lo_q;
  logic [31:0]        pend_hi;
  logic [31:0]        pend_lo;
  logic               cancel;
  logic               accept;
  logic               last;
  logic               is_mul;
  logic               is_div;
  logic               is_mthi;
  logic               is_mtlo;
  logic signed [63:0] a_sx;
  logic signed [63:0] b_sx;
  logic [63:0]        prod;
  logic [31:0]        quot;
  logic [31:0]        rem;

`ifdef MD_CANCEL_EN
  assign cancel = md.cancel_i;
`else
  assign cancel = 1'b0;
`endif

  always_comb begin
    is_mul  = (md.md_op_i == 3'd0) || (md.md_op_i == 3'd1);
    is_div  = (md.md_op_i == 3'd2) || (md.md_op_i == 3'd3);
    is_mthi = (md.md_op_i == 3'd4);
    is_mtlo = (md.md_op_i == 3'd5);
    accept  = (state == IDLE) && md.start_i && !cancel;
    last    = (cnt == 4'd1);
  end

  // The result is formed at issue time, so the busy window only models latency.
  always_comb begin
    a_sx = {{32{md.a_i[31]}}, md.a_i};
    b_sx = {{32{md.b_i[31]}}, md.b_i};
    if (md.md_op_i == 3'd0) begin
      prod = a_sx * b_sx;
    end else begin
      prod = {32'd0, md.a_i} * {32'd0, md.b_i};
    end
    if (md.b_i == 32'd0) begin
      quot = 32'hFFFF_FFFF;
      rem  = md.a_i;
    end else if (md.md_op_i == 3'd2 && md.a_i == 32'h8000_0000 && md.b_i == 32'hFFFF_FFFF) begin
      quot = 32'h8000_0000;
      rem  = 32'd0;
    end else if (md.md_op_i == 3'd2) begin
      quot = 32'($signed(md.a_i) / $signed(md.b_i));
      rem  = 32'($signed(md.a_i) % $signed(md.b_i));
    end else begin
      quot = md.a_i / md.b_i;
      rem  = md.a_i % md.b_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept && is_mul) begin
          next_state = MUL;
        end else if (accept && is_div) begin
          next_state = DIV;
        end
      end
      MUL, DIV: begin
        if (cancel || last) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Cancel outranks the final-cycle commit, so a squashed op never reaches HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else if (state == IDLE) begin
      if (accept) begin
        if (is_mul) begin
          pend_hi <= prod[63:32];
          pend_lo <= prod[31:0];
          cnt     <= 4'(MUL_CYCLES);
        end else if (is_div) begin
          pend_hi <= rem;
          pend_lo <= quot;
          cnt     <= 4'(DIV_CYCLES);
        end else if (is_mthi) begin
          hi_q <= md.a_i;
        end else if (is_mtlo) begin
          lo_q <= md.a_i;
        end
      end
    end else if (cancel) begin
      cnt <= 4'd0;
    end else if (last) begin
      hi_q <= pend_hi;
      lo_q <= pend_lo;
      cnt  <= 4'd0;
    end else begin
      cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    md.hi_o    = hi_q;
    md.lo_o    = lo_q;
    md.busy_o  = (state != IDLE);
    md.stall_o = md.d_uses_md_i & ((state != IDLE) | md.start_i);
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer with hand-computed HI/LO results, busy lengths and stall windows.
// Define MD_CANCEL_EN on both the RTL and the bench to exercise the cancel path.
module tb_md_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  md_sequencer_if bus ();

  md_sequencer #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start_i = start;
    bus.md_op_i = op;
    bus.a_i     = a;
    bus.b_i     = b;
  endtask

  // Issue one multi-cycle op, count busy and stall cycles, then compare the committed HI/LO.
  task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int n, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                       input logic duse, input logic inject);
    int busy_cnt;
    int stall_cnt;
    @(negedge clk);
    bus.d_uses_md_i = duse;
    applyStimulus(1'b1, op, a, b);
    #1;
    stall_cnt = int'(bus.stall_o);
    @(negedge clk);
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
    busy_cnt = 0;
    while (bus.busy_o && busy_cnt < 40) begin
      if (busy_cnt == 0) begin
        checkOutput({tag, "_hold_hi"}, bus.hi_o, model_hi);
        checkOutput({tag, "_hold_lo"}, bus.lo_o, model_lo);
      end
      busy_cnt++;
      stall_cnt += int'(bus.stall_o);
      if (inject && busy_cnt == 2) applyStimulus(1'b1, 3'd4, 32'hDEAD_BEEF, 32'd0);
      else applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
      @(negedge clk);
    end
    checkOutput({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(n));
    checkOutput({tag, "_stall_cycles"}, 64'(stall_cnt), duse ? 64'(n + 1) : 64'd0);
    checkOutput({tag, "_stall_after"}, bus.stall_o, 1'b0);
    checkOutput({tag, "_hi"}, bus.hi_o, exp_hi);
    checkOutput({tag, "_lo"}, bus.lo_o, exp_lo);
    model_hi = exp_hi;
    model_lo = exp_lo;
    bus.d_uses_md_i = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    reset = 1'b0;
    bus.d_uses_md_i = 1'b0;
`ifdef MD_CANCEL_EN
    bus.cancel_i = 1'b0;
`endif
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
    #12;
    checkOutput("rst_busy", bus.busy_o, 1'b0);
    checkOutput("rst_hi", bus.hi_o, 32'd0);
    checkOutput("rst_lo", bus.lo_o, 32'd0);
    checkOutput("rst_stall", bus.stall_o, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // MTHI then MTLO back to back: single-cycle writes, never busy.
    @(negedge clk);
    applyStimulus(1'b1, 3'd4, 32'h1234_5678, 32'd0);
    @(negedge clk);
    checkOutput("mthi_hi", bus.hi_o, 32'h1234_5678);
    checkOutput("mthi_lo", bus.lo_o, 32'd0);
    checkOutput("mthi_busy", bus.busy_o, 1'b0);
    applyStimulus(1'b1, 3'd5, 32'h9, 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
    checkOutput("mtlo_hi", bus.hi_o, 32'h1234_5678);
    checkOutput("mtlo_lo", bus.lo_o, 32'h9);
    checkOutput("mtlo_busy", bus.busy_o, 1'b0);
    model_hi = 32'h1234_5678;
    model_lo = 32'h9;

    // Reserved opcode leaves everything untouched.
    @(negedge clk);
    applyStimulus(1'b1, 3'd6, 32'hAAAA_AAAA, 32'h5);
    @(negedge clk);
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
    checkOutput("rsvd_busy", bus.busy_o, 1'b0);
    checkOutput("rsvd_hi", bus.hi_o, model_hi);
    checkOutput("rsvd_lo", bus.lo_o, model_lo);

    // Reset during the fourth DIV busy cycle aborts it.
    @(negedge clk);
    applyStimulus(1'b1, 3'd3, 32'd100, 32'd7);
    @(negedge clk);
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("abort_busy_before", bus.busy_o, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("abort_busy", bus.busy_o, 1'b0);
    checkOutput("abort_hi", bus.hi_o, 32'd0);
    checkOutput("abort_lo", bus.lo_o, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("abort_late_busy", bus.busy_o, 1'b0);
    checkOutput("abort_late_hi", bus.hi_o, 32'd0);
    checkOutput("abort_late_lo", bus.lo_o, 32'd0);
    model_hi = 32'd0;
    model_lo = 32'd0;

    runOp("mult",  3'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 1'b0);
    runOp("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'h2,         32'hFFFF_FFFA, 1'b0, 1'b0);
    runOp("div",   3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    runOp("divu0", 3'd3, 32'd7, 32'd0, 10, 32'd7, 32'hFFFF_FFFF, 1'b0, 1'b0);
    runOp("divov", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
    runOp("divneg", 3'd2, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD, 1'b0, 1'b0);
    runOp("divu", 3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b0, 1'b0);
    runOp("stall_on",  3'd0, 32'd5, 32'd6, 5, 32'd0, 32'd30, 1'b1, 1'b0);
    runOp("stall_off", 3'd0, 32'd5, 32'd6, 5, 32'd0, 32'd30, 1'b0, 1'b0);
    runOp("ignored", 3'd0, 32'd3, 32'd4, 5, 32'd0, 32'd12, 1'b0, 1'b1);

`ifdef MD_CANCEL_EN
    // Cancel on the third DIV busy cycle drops the op; a cancelled MTHI never writes.
    @(negedge clk);
    applyStimulus(1'b1, 3'd2, 32'd100, 32'd7);
    @(negedge clk);
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    bus.cancel_i = 1'b1;
    @(negedge clk);
    bus.cancel_i = 1'b0;
    checkOutput("cancel_busy", bus.busy_o, 1'b0);
    repeat (12) @(negedge clk);
    checkOutput("cancel_hi", bus.hi_o, model_hi);
    checkOutput("cancel_lo", bus.lo_o, model_lo);
    applyStimulus(1'b1, 3'd4, 32'hCAFE_0000, 32'd0);
    bus.cancel_i = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
    bus.cancel_i = 1'b0;
    checkOutput("cancel_start_hi", bus.hi_o, model_hi);
    checkOutput("cancel_start_busy", bus.busy_o, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
